branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- In-order buffer of in-flight branch predictions between the predictor output and the branch execution/trace stage.
- Captures each issued prediction (PC + predicted direction) and waits for the branch to resolve.
- On resolution, drives the predictor update interface (br_result, correct, PC) one cycle later, flushes wrong-path entries on a mispredict, and keeps branch and mispredict statistics.

Parameters:
- DEPTH, 8, number of in-flight entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- pred_valid_i  in  1  prediction issued this cycle.
- pred_ready_o  out  1  queue can accept; equals !full.
- pred_pc_i  in  32  branch PC (same idx as presented to the predictor).
- pred_taken_i  in  1  predictor output for that PC.
- res_valid_i  in  1  oldest outstanding branch resolves this cycle.
- res_taken_i  in  1  actual direction.
- upd_valid_o  out  1  update strobe to predictor.
- upd_pc_o  out  32  PC of the resolved branch.
- upd_br_result_o  out  1  actual direction; drives predictor br_result_i.
- upd_correct_o  out  1  prediction matched; drives predictor correct_i.
- flush_o  out  1  mispredict pulse; upstream discards younger work.
- underflow_o  out  1  sticky: a resolve arrived while empty.
- count_o  out  PTR_W+1  current occupancy.
- br_count_o  out  CNT_W  resolved branches.
- mispred_count_o  out  CNT_W  mispredicted branches.

Behaviour:
- Reset (rst_i high at posedge):
  - pointers and count = 0; pred_ready_o = 1;
  - upd_valid_o, upd_pc_o, upd_br_result_o, upd_correct_o, flush_o, underflow_o = 0;
  - both statistics counters = 0.
  - Reset mid-operation drops all entries with no update emitted.
- Push: when pred_valid_i && pred_ready_o, write {pc, taken} at the write pointer. Pointer wraps modulo DEPTH.
- Pop: when res_valid_i && count != 0.
  - Head is read combinationally and popped.
  - mismatch = head.taken != res_taken_i.
- Update registers (next cycle, 1-cycle latency from resolve):
  - upd_valid_o = 1; upd_pc_o = head.pc; upd_br_result_o = res_taken_i; upd_correct_o = !mismatch.
  - upd_* hold their last values when upd_valid_o = 0.
- Mispredict:
  - flush_o pulses with upd_valid_o for exactly one cycle.
  - All remaining entries are cleared: count = 0, rd = wr pointer.
  - A push in the same cycle is discarded as wrong-path.
- Simultaneous push and correct pop: both happen and count is unchanged. Push and pop in the same cycle while full is not possible, because pred_ready_o depends only on registered full.
- Full: pred_ready_o = 0; pred_valid_i is ignored and nothing is overwritten.
- Empty resolve: no pop and no update; underflow_o set, cleared only by rst_i.
- Statistics:
  - br_count_o increments on every pop; mispred_count_o increments on every mismatch pop.
  - Both saturate at all-ones.
- No combinational path from res_* to upd_* or flush_o. pred_ready_o is a registered-state function only.

Decomposition:
- Shared package brq_pkg holds:
  - typedef brq_entry_t {logic [31:0] pc; logic taken;};
  - the default DEPTH and CNT_W constants.
- Sub-module sat_counter (parameter W; inputs inc, clr; output value) is instantiated twice for the statistics.
- Storage and pointers stay in the top module.

Test Plan:
- Reset, then push 3 predictions (PC 0x100/T, 0x104/N, 0x108/T) and resolve T,N,T -> three upd_valid_o pulses, each one cycle after its resolve, PCs in order, correct=1; flush_o never set; br_count=3, mispred_count=0.
- Push 4 entries, resolve the first with the opposite direction -> upd_correct_o=0, flush_o one pulse; count_o=0 next cycle; mispred_count=1; a subsequent resolve sets underflow_o.
- Push DEPTH=8 entries -> pred_ready_o=0. A 9th push is ignored; after one correct resolve, pred_ready_o=1 and 8 more pushes/pops wrap the pointers with correct PC order.
- Push and correct resolve in the same cycle at count=3 -> count stays 3; the update carries the old head PC.
- Mispredicting resolve concurrent with a push of 0x200 -> the push is discarded; count_o=0; 0x200 never appears on upd_pc_o.
- Assert rst_i with 5 entries queued and a resolve pending -> no upd_valid_o after reset; all outputs are at their reset values; counters read 0.

Source files
------------

// File: rtl/brq_pkg.sv
// Shared types and default sizing for the branch resolve queue.
package brq_pkg;

    localparam int BRQ_DEPTH = 8;
    localparam int BRQ_CNT_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } brq_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            value_q <= '0;
        end else if (inc_i && (value_q != '1)) begin
            value_q <= value_q + W'(1);
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; emits predictor updates one
// cycle after each resolve and flushes wrong-path entries on a mispredict.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = BRQ_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pred_valid_i,
    output logic             pred_ready_o,
    input  logic [31:0]      pred_pc_i,
    input  logic             pred_taken_i,
    input  logic             res_valid_i,
    input  logic             res_taken_i,
    output logic             upd_valid_o,
    output logic [31:0]      upd_pc_o,
    output logic             upd_br_result_o,
    output logic             upd_correct_o,
    output logic             flush_o,
    output logic             underflow_o,
    output logic [PTR_W:0]   count_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mispred_count_o
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    brq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             upd_valid_q, upd_br_result_q, upd_correct_q, flush_q, underflow_q;
    logic [31:0]      upd_pc_q;

    brq_entry_t head;
    logic       full, empty, pop, mismatch, push;

    assign head     = mem_q[rd_q];
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign pop      = res_valid_i && !empty;
    assign mismatch = pop && (head.taken != res_taken_i);
    // A push racing a mispredict is younger than the bad branch, so it is dropped.
    assign push     = pred_valid_i && !full && !mismatch;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (mismatch) begin
            rd_d    = wr_q;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_ONE;
            if (pop)  rd_d = rd_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_q] <= '{pc: pred_pc_i, taken: pred_taken_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q            <= '0;
            wr_q            <= '0;
            count_q         <= '0;
            upd_valid_q     <= 1'b0;
            upd_pc_q        <= '0;
            upd_br_result_q <= 1'b0;
            upd_correct_q   <= 1'b0;
            flush_q         <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            upd_valid_q <= pop;
            flush_q     <= mismatch;
            if (pop) begin
                upd_pc_q        <= head.pc;
                upd_br_result_q <= res_taken_i;
                upd_correct_q   <= !mismatch;
            end
            if (res_valid_i && empty) underflow_q <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .inc_i   (pop),
        .value_o (br_count_o)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .inc_i   (mismatch),
        .value_o (mispred_count_o)
    );

    assign pred_ready_o    = !full;
    assign upd_valid_o     = upd_valid_q;
    assign upd_pc_o        = upd_pc_q;
    assign upd_br_result_o = upd_br_result_q;
    assign upd_correct_o   = upd_correct_q;
    assign flush_o         = flush_q;
    assign underflow_o     = underflow_q;
    assign count_o         = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed and random stimulus against a queue-based reference model of the branch resolve queue.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 32;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             pred_valid_i = 1'b0;
    logic             pred_ready_o;
    logic [31:0]      pred_pc_i = '0;
    logic             pred_taken_i = 1'b0;
    logic             res_valid_i = 1'b0;
    logic             res_taken_i = 1'b0;
    logic             upd_valid_o;
    logic [31:0]      upd_pc_o;
    logic             upd_br_result_o;
    logic             upd_correct_o;
    logic             flush_o;
    logic             underflow_o;
    logic [PTR_W:0]   count_o;
    logic [CNT_W-1:0] br_count_o;
    logic [CNT_W-1:0] mispred_count_o;

    branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pred_valid_i    (pred_valid_i),
        .pred_ready_o    (pred_ready_o),
        .pred_pc_i       (pred_pc_i),
        .pred_taken_i    (pred_taken_i),
        .res_valid_i     (res_valid_i),
        .res_taken_i     (res_taken_i),
        .upd_valid_o     (upd_valid_o),
        .upd_pc_o        (upd_pc_o),
        .upd_br_result_o (upd_br_result_o),
        .upd_correct_o   (upd_correct_o),
        .flush_o         (flush_o),
        .underflow_o     (underflow_o),
        .count_o         (count_o),
        .br_count_o      (br_count_o),
        .mispred_count_o (mispred_count_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t        q[$];
    logic        m_upd_valid, m_br, m_correct, m_flush, m_under;
    logic [31:0] m_pc;
    longint      m_br_cnt, m_mis_cnt;
    bit          saw_200;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic head_taken();
        if (q.size() == 0) return 1'b0;
        return q[0].taken;
    endfunction

    task automatic model_edge();
        ent_t h;
        bit   ready, push, pop, mis;
        if (rst_i) begin
            q.delete();
            m_upd_valid = 0; m_pc = '0; m_br = 0; m_correct = 0;
            m_flush = 0; m_under = 0; m_br_cnt = 0; m_mis_cnt = 0;
            return;
        end
        ready = q.size() < DEPTH;
        push  = pred_valid_i && ready;
        pop   = res_valid_i && q.size() > 0;
        mis   = 0;
        if (res_valid_i && q.size() == 0) m_under = 1;
        m_upd_valid = pop;
        m_flush     = 0;
        if (pop) begin
            h = q.pop_front();
            mis = (h.taken != res_taken_i);
            m_pc = h.pc;
            m_br = res_taken_i;
            m_correct = !mis;
            if (m_br_cnt < 64'hFFFF_FFFF) m_br_cnt++;
            if (mis) begin
                if (m_mis_cnt < 64'hFFFF_FFFF) m_mis_cnt++;
                q.delete();
                m_flush = 1;
            end
        end
        if (push && !mis) q.push_back('{pc: pred_pc_i, taken: pred_taken_i});
    endtask

    task automatic check_all();
        chk("pred_ready", 64'(pred_ready_o), 64'(q.size() < DEPTH));
        chk("count", 64'(count_o), 64'(q.size()));
        chk("upd_valid", 64'(upd_valid_o), 64'(m_upd_valid));
        chk("upd_pc", 64'(upd_pc_o), 64'(m_pc));
        chk("upd_br_result", 64'(upd_br_result_o), 64'(m_br));
        chk("upd_correct", 64'(upd_correct_o), 64'(m_correct));
        chk("flush", 64'(flush_o), 64'(m_flush));
        chk("underflow", 64'(underflow_o), 64'(m_under));
        chk("br_count", 64'(br_count_o), 64'(m_br_cnt));
        chk("mispred_count", 64'(mispred_count_o), 64'(m_mis_cnt));
        if (upd_valid_o === 1'b1 && upd_pc_o === 32'h200) saw_200 = 1;
    endtask

    task automatic step(input logic r, input logic pv, input logic [31:0] pc, input logic pt,
                        input logic rv, input logic rt);
        rst_i = r; pred_valid_i = pv; pred_pc_i = pc; pred_taken_i = pt;
        res_valid_i = rv; res_taken_i = rt;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        logic pv, rv, rt, r;
        saw_200 = 0;
        // Reset
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Three correct predictions resolved in order
        step(0, 1, 32'h100, 1, 0, 0);
        step(0, 1, 32'h104, 0, 0, 0);
        step(0, 1, 32'h108, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        idle();
        chk("br_count_after_3", 64'(br_count_o), 64'd3);
        chk("mispred_after_3", 64'(mispred_count_o), 64'd0);

        // Mispredict on first of four, then an empty resolve
        for (int i = 0; i < 4; i++) step(0, 1, 32'h300 + 32'(4 * i), 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle();
        chk("count_after_flush", 64'(count_o), 64'd0);
        step(0, 0, 0, 0, 1, 1);
        idle();
        chk("underflow_sticky", 64'(underflow_o), 64'd1);

        // Fill to full, ignored 9th push, then wrap with simultaneous push/pop
        for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h400 + 32'(4 * i), 1'(i & 1), 0, 0);
        chk("full_ready_low", 64'(pred_ready_o), 64'd0);
        step(0, 1, 32'h999, 1, 0, 0);
        step(0, 0, 0, 0, 1, head_taken());
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 32'h500 + 32'(4 * i), 1'(i % 3 == 0), 1, head_taken());
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, head_taken());
        idle();

        // Push + correct pop at count 3
        for (int i = 0; i < 3; i++) step(0, 1, 32'h600 + 32'(4 * i), 0, 0, 0);
        step(0, 1, 32'h60c, 1, 1, head_taken());
        chk("count_hold_3", 64'(count_o), 64'd3);

        // Mispredict concurrent with push of 0x200
        step(0, 1, 32'h200, 1, 1, !head_taken());
        idle();
        step(0, 0, 0, 0, 1, 0);
        chk("pc200_dropped", 64'(saw_200), 64'd0);

        // Reset with entries queued and a resolve pending
        for (int i = 0; i < 5; i++) step(0, 1, 32'h700 + 32'(4 * i), 1, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        idle();
        chk("post_rst_count", 64'(count_o), 64'd0);
        chk("post_rst_br", 64'(br_count_o), 64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            pv = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 45);
            rt = ($urandom_range(0, 99) < 85) ? head_taken() : !head_taken();
            step(r, pv, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), rv, rt);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 1, head_taken());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
